// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory port: size encoding, FSM states,
// request bundle and the byte-lane helpers used at grant time.
package lsu_pkg;

  localparam int unsigned Xlen     = 32;
  localparam int unsigned NumBytes = Xlen / 8;

  typedef enum logic [1:0] {
    SzB   = 2'd0,
    SzH   = 2'd1,
    SzW   = 2'd2,
    SzIll = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitRsp
  } state_e;

  typedef struct packed {
    logic                we;
    logic [Xlen-1:0]     addr;
    logic [Xlen-1:0]     wdata;
    logic [NumBytes-1:0] be;
  } mem_req_t;

  function automatic logic misaligned(size_e sz, logic [1:0] a);
    case (sz)
      SzB:     return 1'b0;
      SzH:     return a[0];
      SzW:     return |a;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [NumBytes-1:0] be_gen(size_e sz, logic [1:0] a);
    case (sz)
      SzB:     return 4'b0001 << a;
      SzH:     return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across lanes so the be mask alone selects bytes.
  function automatic logic [Xlen-1:0] wdata_gen(size_e sz, logic [Xlen-1:0] d);
    case (sz)
      SzB:     return {4{d[7:0]}};
      SzH:     return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select and sign/zero extension of a read word.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = Xlen
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      lane_i,
  input  size_e           size_i,
  input  logic            uns_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[8*lane_i +: 8];
    half_sel = rdata_i[16*lane_i[1] +: 16];
    unique case (size_i)
      SzB:     data_o = {{(XLEN-8){byte_sel[7] & ~uns_i}}, byte_sel};
      SzH:     data_o = {{(XLEN-16){half_sel[15] & ~uns_i}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Arbitrates load/store queue heads onto a single word-wide memory port with one
// outstanding access; returns extended load data and store completions.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN         = Xlen,
  parameter int unsigned LDQ_IDX_W    = 3,
  parameter int unsigned SDQ_IDX_W    = 3,
  parameter int unsigned TAG_W        = 6,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned IdxW = (LDQ_IDX_W > SDQ_IDX_W) ? LDQ_IDX_W : SDQ_IDX_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 ld_vld_i,
  input  logic [XLEN-1:0]      ld_addr_i,
  input  logic [1:0]           ld_size_i,
  input  logic                 ld_unsigned_i,
  input  logic [TAG_W-1:0]     ld_tag_i,
  input  logic [LDQ_IDX_W-1:0] ld_idx_i,
  output logic                 ld_en_o,
  input  logic                 st_vld_i,
  input  logic [XLEN-1:0]      st_addr_i,
  input  logic [XLEN-1:0]      st_data_i,
  input  logic [1:0]           st_size_i,
  input  logic [SDQ_IDX_W-1:0] st_idx_i,
  output logic                 st_en_o,
  output logic                 mem_req_vld_o,
  input  logic                 mem_req_rdy_i,
  output logic                 mem_req_we_o,
  output logic [XLEN-1:0]      mem_req_addr_o,
  output logic [XLEN-1:0]      mem_req_wdata_o,
  output logic [3:0]           mem_req_be_o,
  input  logic                 mem_rsp_vld_i,
  input  logic [XLEN-1:0]      mem_rsp_data_i,
  output logic                 wb_vld_o,
  output logic [TAG_W-1:0]     wb_tag_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic [LDQ_IDX_W-1:0] wb_idx_o,
  output logic                 st_done_o,
  output logic [SDQ_IDX_W-1:0] st_done_idx_o,
  output logic                 exc_vld_o,
  output logic                 exc_is_st_o,
  output logic [IdxW-1:0]      exc_idx_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  state_e                 state_q, state_d;
  mem_req_t               req_q, req_d;
  logic                   is_ld_q, is_ld_d;
  logic [1:0]             lane_q, lane_d;
  size_e                  size_q, size_d;
  logic                   uns_q, uns_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [LDQ_IDX_W-1:0]   ldq_idx_q, ldq_idx_d;
  logic [SDQ_IDX_W-1:0]   sdq_idx_q, sdq_idx_d;
  logic                   squash_q, squash_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   wb_vld_q, wb_vld_d;
  logic [XLEN-1:0]        wb_data_q, wb_data_d;
  logic                   st_done_q, st_done_d;
  logic                   exc_vld_q, exc_vld_d;
  logic                   exc_is_st_q, exc_is_st_d;
  logic [XLEN-1:0]        ld_aligned;
  size_e                  ld_sz, st_sz;

  assign ld_sz = size_e'(ld_size_i);
  assign st_sz = size_e'(st_size_i);

  lsu_load_align #(
    .XLEN(XLEN)
  ) u_align (
    .rdata_i(mem_rsp_data_i),
    .lane_i (lane_q),
    .size_i (size_q),
    .uns_i  (uns_q),
    .data_o (ld_aligned)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    is_ld_d     = is_ld_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    tag_d       = tag_q;
    ldq_idx_d   = ldq_idx_q;
    sdq_idx_d   = sdq_idx_q;
    squash_d    = squash_q;
    cnt_d       = cnt_q;
    wb_data_d   = wb_data_q;
    exc_is_st_d = exc_is_st_q;
    wb_vld_d    = 1'b0;
    st_done_d   = 1'b0;
    exc_vld_d   = 1'b0;
    ld_en_o     = 1'b0;
    st_en_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (st_vld_i && !(ld_vld_i && cnt_q == CntMax)) begin
          st_en_o   = 1'b1;
          sdq_idx_d = st_idx_i;
          if (misaligned(st_sz, st_addr_i[1:0])) begin
            exc_vld_d   = 1'b1;
            exc_is_st_d = 1'b1;
          end else begin
            req_d   = '{we: 1'b1, addr: {st_addr_i[XLEN-1:2], 2'b00},
                        wdata: wdata_gen(st_sz, st_data_i), be: be_gen(st_sz, st_addr_i[1:0])};
            is_ld_d = 1'b0;
            state_d = StReq;
          end
        end else if (ld_vld_i && !flush_i) begin
          ld_en_o   = 1'b1;
          ldq_idx_d = ld_idx_i;
          if (misaligned(ld_sz, ld_addr_i[1:0])) begin
            exc_vld_d   = 1'b1;
            exc_is_st_d = 1'b0;
          end else begin
            req_d   = '{we: 1'b0, addr: {ld_addr_i[XLEN-1:2], 2'b00},
                        wdata: '0, be: be_gen(ld_sz, ld_addr_i[1:0])};
            is_ld_d = 1'b1;
            lane_d  = ld_addr_i[1:0];
            size_d  = ld_sz;
            uns_d   = ld_unsigned_i;
            tag_d   = ld_tag_i;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (is_ld_q && flush_i) squash_d = 1'b1;
        if (mem_req_rdy_i) begin
          if (is_ld_q) begin
            state_d = StWaitRsp;
          end else begin
            st_done_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StWaitRsp: begin
        if (flush_i) squash_d = 1'b1;
        if (mem_rsp_vld_i) begin
          wb_vld_d  = !(squash_q || flush_i);
          wb_data_d = ld_aligned;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) squash_d = 1'b0;

    // Starvation counter only tracks stores granted past a waiting load.
    if (ld_en_o || !ld_vld_i) begin
      cnt_d = '0;
    end else if (st_en_o && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      req_q       <= '0;
      is_ld_q     <= 1'b0;
      lane_q      <= '0;
      size_q      <= SzB;
      uns_q       <= 1'b0;
      tag_q       <= '0;
      ldq_idx_q   <= '0;
      sdq_idx_q   <= '0;
      squash_q    <= 1'b0;
      cnt_q       <= '0;
      wb_vld_q    <= 1'b0;
      wb_data_q   <= '0;
      st_done_q   <= 1'b0;
      exc_vld_q   <= 1'b0;
      exc_is_st_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      is_ld_q     <= is_ld_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      tag_q       <= tag_d;
      ldq_idx_q   <= ldq_idx_d;
      sdq_idx_q   <= sdq_idx_d;
      squash_q    <= squash_d;
      cnt_q       <= cnt_d;
      wb_vld_q    <= wb_vld_d;
      wb_data_q   <= wb_data_d;
      st_done_q   <= st_done_d;
      exc_vld_q   <= exc_vld_d;
      exc_is_st_q <= exc_is_st_d;
    end
  end

  assign mem_req_vld_o   = (state_q == StReq);
  assign mem_req_we_o    = req_q.we;
  assign mem_req_addr_o  = req_q.addr;
  assign mem_req_wdata_o = req_q.wdata;
  assign mem_req_be_o    = req_q.be;
  assign busy_o          = (state_q != StIdle);

  assign wb_vld_o      = wb_vld_q;
  assign wb_data_o     = wb_data_q;
  assign wb_tag_o      = wb_vld_q ? tag_q : '0;
  assign wb_idx_o      = wb_vld_q ? ldq_idx_q : '0;
  assign st_done_o     = st_done_q;
  assign st_done_idx_o = st_done_q ? sdq_idx_q : '0;
  assign exc_vld_o     = exc_vld_q;
  assign exc_is_st_o   = exc_vld_q & exc_is_st_q;
  assign exc_idx_o     = !exc_vld_q ? '0 : exc_is_st_q ? IdxW'(sdq_idx_q) : IdxW'(ldq_idx_q);

endmodule
